pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter RESET_HOLD, default 4, meaning the number of cycles all stages stay disabled after reset release (range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port fetch_stall_req, input, 1 bit: fetch stage (1) cannot deliver an instruction this cycle.
REQ-005 SHALL have port alu_stall_req, input, 1 bit: ALU stage (3) must hold, i.e. a load/CSR result is not yet forwardable.
REQ-006 SHALL have port mem_stall_req, input, 1 bit: memory stage (4) waits on a data-bus acknowledge.
REQ-007 SHALL have port alu_flush_req, input, 1 bit: a taken branch or jump was resolved in stage 3.
REQ-008 SHALL have port wb_flush_req, input, 1 bit: a trap or mret was taken in writeback stage (5).
REQ-009 SHALL have port stage_ce, output, 5 bits: registered per-stage enable; bit0 = fetch ... bit4 = writeback.
REQ-010 SHALL have port stage_stall, output, 5 bits: combinational per-stage hold; same bit order.
REQ-011 SHALL have port stage_flush, output, 5 bits: combinational per-stage squash; same bit order.
REQ-012 SHALL have port stall_count, output, 32 bits: registered count of cycles with any stage_stall bit high.

Function
REQ-013 SHALL implement FSM INIT -> RUN; INIT loads hold counter with RESET_HOLD-1 and decrements to 0, then moves to RUN on the following edge; RUN is terminal until reset.
REQ-014 SHALL hold stage_ce = 5'b00000 while in INIT and drive stage_ce[0] = 1 on the first RUN edge and every RUN cycle after.
REQ-015 SHALL drive stage_stall = 5'b11111 in INIT and stage_flush = 0 in INIT; all request inputs are ignored in INIT.
REQ-016 SHALL compute stalls in RUN with backward propagation: stall[4]=0; stall[3]=mem_stall_req; stall[2]=alu_stall_req|stall[3]; stall[1]=stall[2]; stall[0]=fetch_stall_req|stall[1].
REQ-017 SHALL accept alu_flush_req only when stage_ce[2]=1 and stall[2]=0; the accepted flush sets stage_flush[1:0]=2'b11.
REQ-018 SHALL accept wb_flush_req only when stage_ce[4]=1; the accepted flush sets stage_flush[3:0]=4'b1111 and forces stage_stall[3:0]=0 (flush overrides every stall).
REQ-019 SHALL, when an accepted wb flush and an accepted alu flush coincide, apply the wb flush only.
REQ-020 SHALL update each stage_ce[k], k=1..4, every RUN edge in priority order: flush of stage k-1 -> 0; else stall[k] -> hold; else stall[k-1] -> 0 (bubble); else stage_ce[k-1].
REQ-021 SHALL additionally clear stage_ce[k] when stage_flush[k]=1 and stall[k]=0 does not apply, i.e. a flushed, stalled stage is cleared rather than held.
REQ-022 SHALL give one-cycle latency from any request to the resulting stage_ce change; stage_stall/stage_flush respond in the same cycle.
REQ-023 SHALL increment stall_count by 1 each RUN cycle with |stage_stall=1, wrapping from 0xFFFFFFFF to 0; it SHALL not count during INIT.

Reset
REQ-024 SHALL on rst=1 asynchronously set: state INIT, hold counter RESET_HOLD-1, stage_ce=0, stall_count=0.
REQ-025 SHALL, on reset asserted mid-operation, discard all in-flight enables immediately and restart the full INIT sequence after release.

Verification
REQ-026 Reset release, RESET_HOLD=4, no requests -> stage_ce stays 0 for 4 edges, then fills 00001, 00011, 00111, 01111, 11111 on successive edges; stall_count=0.
REQ-027 Full pipe, alu_stall_req=1 for 2 cycles -> stage_stall=00111 both cycles; stage_ce[3] goes 0 for 2 cycles (bubbles) then refills; stall_count +2.
REQ-028 Full pipe, mem_stall_req=1 for 3 cycles -> stage_stall=01111; stage_ce[4] drops to 0 for 3 cycles; stage_ce[3:0] hold 1111.
REQ-029 Full pipe, alu_flush_req=1 one cycle -> stage_flush=00011; next edge stage_ce=11001 with stage_ce[0]=1; same pulse while alu_stall_req=1 -> stage_flush=00000.
REQ-030 Full pipe, mem_stall_req=1 and wb_flush_req=1 together (alu_flush_req=1 too) -> stage_flush=01111, stage_stall=00000; next edge stage_ce=00001.
REQ-031 rst pulsed while stage_ce=11111 and stall_count=7 -> stage_ce=0 and stall_count=0 without a clock edge; INIT repeats for 4 cycles.

Source files
------------

// File: rtl/pipeline_ctrl_if.sv
// Hazard-control bundle between the five pipeline stages and pipeline_ctrl.
// Stages (master) raise stall/flush requests; the controller (slave) returns enables, holds and squashes.
interface pipeline_ctrl_if;
    logic        fetch_stall_req;
    logic        alu_stall_req;
    logic        mem_stall_req;
    logic        alu_flush_req;
    logic        wb_flush_req;
    logic [4:0]  stage_ce;
    logic [4:0]  stage_stall;
    logic [4:0]  stage_flush;
    logic [31:0] stall_count;

    modport master (
        output fetch_stall_req, alu_stall_req, mem_stall_req, alu_flush_req, wb_flush_req,
        input  stage_ce, stage_stall, stage_flush, stall_count
    );

    modport slave (
        input  fetch_stall_req, alu_stall_req, mem_stall_req, alu_flush_req, wb_flush_req,
        output stage_ce, stage_stall, stage_flush, stall_count
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: stall/flush are combinational, stage_ce moves one cycle after a request.
// Stalls propagate backward from the requesting stage; a writeback flush overrides every stall.
module pipeline_ctrl #(
    parameter int unsigned RESET_HOLD = 4
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  ctrl
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(RESET_HOLD - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_hold;
    logic [4:0]  r_ce;
    logic [4:0]  w_ce_nxt;
    logic [4:0]  w_stall_raw;
    logic [4:0]  w_stall;
    logic [4:0]  w_flush;
    logic        w_run;
    logic        w_wb_flush_acc;
    logic        w_alu_flush_acc;
    logic [31:0] r_stall_count;

    assign w_run = (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_INIT;
            r_hold  <= HOLD_INIT;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT && r_hold != 8'd0)
                r_hold <= r_hold - 8'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_INIT && r_hold == 8'd0)
            w_state_nxt = S_RUN;
    end

    // A stall in stage k also freezes everything upstream of it.
    always_comb begin
        w_stall_raw    = '0;
        w_stall_raw[3] = ctrl.mem_stall_req;
        w_stall_raw[2] = ctrl.alu_stall_req | w_stall_raw[3];
        w_stall_raw[1] = w_stall_raw[2];
        w_stall_raw[0] = ctrl.fetch_stall_req | w_stall_raw[1];

        w_wb_flush_acc  = w_run & ctrl.wb_flush_req & r_ce[4];
        w_alu_flush_acc = w_run & ctrl.alu_flush_req & r_ce[2] & ~w_stall_raw[2] & ~w_wb_flush_acc;

        w_stall = '0;
        w_flush = '0;
        if (!w_run) begin
            w_stall = 5'b11111;
        end else if (w_wb_flush_acc) begin
            w_flush = 5'b01111;
        end else begin
            w_stall = w_stall_raw;
            if (w_alu_flush_acc)
                w_flush = 5'b00011;
        end
    end

    // Squash beats hold beats bubble beats advance.
    always_comb begin
        w_ce_nxt = '0;
        if (w_run) begin
            w_ce_nxt[0] = 1'b1;
            for (int k = 1; k < 5; k++) begin
                if (w_flush[k-1] || w_flush[k])
                    w_ce_nxt[k] = 1'b0;
                else if (w_stall[k])
                    w_ce_nxt[k] = r_ce[k];
                else if (w_stall[k-1])
                    w_ce_nxt[k] = 1'b0;
                else
                    w_ce_nxt[k] = r_ce[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce          <= '0;
            r_stall_count <= '0;
        end else begin
            r_ce <= w_ce_nxt;
            if (w_run && (|w_stall))
                r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign ctrl.stage_ce    = r_ce;
    assign ctrl.stage_stall = w_stall;
    assign ctrl.stage_flush = w_flush;
    assign ctrl.stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random requests against a cycle-level model.
module tb_pipeline_ctrl;

    localparam int HOLD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if ifc();

    pipeline_ctrl #(.RESET_HOLD(HOLD)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ifc.slave)
    );

    int vectors = 0;
    int errors  = 0;

    // Model: request bits {wb_flush, alu_flush, mem_stall, alu_stall, fetch_stall}
    int          m_cyc;
    logic [4:0]  m_ce;
    logic [4:0]  m_stall;
    logic [4:0]  m_flush;
    logic [31:0] m_cnt;

    task automatic model_reset();
        m_cyc = 0;
        m_ce  = '0;
        m_cnt = '0;
    endtask

    task automatic apply(input logic [4:0] req);
        int h;
        ifc.fetch_stall_req = req[0];
        ifc.alu_stall_req   = req[1];
        ifc.mem_stall_req   = req[2];
        ifc.alu_flush_req   = req[3];
        ifc.wb_flush_req    = req[4];
        m_stall = '0;
        m_flush = '0;
        if (m_cyc < HOLD) begin
            m_stall = 5'b11111;
        end else begin
            // Every stage at or upstream of the furthest stalling stage holds.
            h = -1;
            if (req[0]) h = 0;
            if (req[1]) h = 2;
            if (req[2]) h = 3;
            for (int s = 0; s < 4; s++)
                if (s <= h) m_stall[s] = 1'b1;
            if (req[4] && m_ce[4]) begin
                m_stall = '0;
                m_flush = 5'b01111;
            end else if (req[3] && m_ce[2] && !m_stall[2]) begin
                m_flush = 5'b00011;
            end
        end
        #1;
    endtask

    task automatic tick();
        logic [4:0] nxt;
        @(posedge clk);
        nxt = '0;
        if (m_cyc >= HOLD) begin
            nxt[0] = 1'b1;
            for (int k = 1; k < 5; k++) begin
                if (m_flush[k-1] || m_flush[k]) nxt[k] = 1'b0;
                else if (m_stall[k])            nxt[k] = m_ce[k];
                else if (m_stall[k-1])          nxt[k] = 1'b0;
                else                            nxt[k] = m_ce[k-1];
            end
            if (m_stall != 5'b0) m_cnt = m_cnt + 32'd1;
        end
        m_ce  = nxt;
        m_cyc = m_cyc + 1;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifc.fetch_stall_req = 1'b0;
        ifc.alu_stall_req   = 1'b0;
        ifc.mem_stall_req   = 1'b0;
        ifc.alu_flush_req   = 1'b0;
        ifc.wb_flush_req    = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifc.fetch_stall_req = 1'b1;
        ifc.alu_stall_req   = 1'b0;
        ifc.mem_stall_req   = 1'b1;
        ifc.alu_flush_req   = 1'b1;
        ifc.wb_flush_req    = 1'b1;
        #1;
        vectors++; if (ifc.stage_ce !== 5'b00000) begin errors++; $display("FAIL reset_ce got %b want 00000", ifc.stage_ce); end
        vectors++; if (ifc.stall_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0d want 0", ifc.stall_count); end
        vectors++; if (ifc.stage_stall !== 5'b11111) begin errors++; $display("FAIL reset_stall got %b want 11111", ifc.stage_stall); end
        vectors++; if (ifc.stage_flush !== 5'b00000) begin errors++; $display("FAIL reset_flush got %b want 00000", ifc.stage_flush); end
        do_reset();
    endtask

    task automatic test_fill();
        logic [4:0] exp_ce [9] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h01, 5'h03, 5'h07, 5'h0f, 5'h1f};
        for (int i = 0; i < 9; i++) begin
            apply(5'b00000);
            vectors++; if (ifc.stage_stall !== m_stall) begin errors++; $display("FAIL fill_stall[%0d] got %b want %b", i, ifc.stage_stall, m_stall); end
            tick();
            vectors++; if (ifc.stage_ce !== exp_ce[i] || m_ce !== exp_ce[i]) begin errors++; $display("FAIL fill_ce[%0d] got %b want %b", i, ifc.stage_ce, exp_ce[i]); end
        end
        vectors++; if (ifc.stall_count !== 32'd0) begin errors++; $display("FAIL fill_count got %0d want 0", ifc.stall_count); end
    endtask

    task automatic test_alu_stall();
        logic [31:0] base;
        base = ifc.stall_count;
        for (int i = 0; i < 2; i++) begin
            apply(5'b00010);
            vectors++; if (ifc.stage_stall !== 5'b00111) begin errors++; $display("FAIL alu_stall_vec[%0d] got %b want 00111", i, ifc.stage_stall); end
            tick();
            vectors++; if (ifc.stage_ce !== m_ce || ifc.stage_ce[3] !== 1'b0) begin errors++; $display("FAIL alu_stall_ce[%0d] got %b want %b", i, ifc.stage_ce, m_ce); end
        end
        for (int i = 0; i < 2; i++) begin
            apply(5'b00000);
            tick();
            vectors++; if (ifc.stage_ce !== m_ce) begin errors++; $display("FAIL alu_refill_ce[%0d] got %b want %b", i, ifc.stage_ce, m_ce); end
        end
        vectors++; if (ifc.stage_ce !== 5'b11111) begin errors++; $display("FAIL alu_refill_full got %b want 11111", ifc.stage_ce); end
        vectors++; if (ifc.stall_count !== base + 32'd2) begin errors++; $display("FAIL alu_stall_count got %0d want %0d", ifc.stall_count, base + 32'd2); end
    endtask

    task automatic test_mem_stall();
        for (int i = 0; i < 3; i++) begin
            apply(5'b00100);
            vectors++; if (ifc.stage_stall !== 5'b01111) begin errors++; $display("FAIL mem_stall_vec[%0d] got %b want 01111", i, ifc.stage_stall); end
            tick();
            vectors++; if (ifc.stage_ce !== 5'b01111 || m_ce !== 5'b01111) begin errors++; $display("FAIL mem_stall_ce[%0d] got %b want 01111", i, ifc.stage_ce); end
        end
        apply(5'b00000);
        tick();
        vectors++; if (ifc.stage_ce !== 5'b11111) begin errors++; $display("FAIL mem_release_ce got %b want 11111", ifc.stage_ce); end
    endtask

    task automatic test_alu_flush();
        apply(5'b01000);
        vectors++; if (ifc.stage_flush !== 5'b00011) begin errors++; $display("FAIL alu_flush_vec got %b want 00011", ifc.stage_flush); end
        tick();
        vectors++; if (ifc.stage_ce !== 5'b11001) begin errors++; $display("FAIL alu_flush_ce got %b want 11001", ifc.stage_ce); end
        for (int i = 0; i < 4; i++) begin
            apply(5'b00000);
            tick();
            vectors++; if (ifc.stage_ce !== m_ce) begin errors++; $display("FAIL alu_flush_refill[%0d] got %b want %b", i, ifc.stage_ce, m_ce); end
        end
        apply(5'b01010);
        vectors++; if (ifc.stage_flush !== 5'b00000) begin errors++; $display("FAIL alu_flush_stalled got %b want 00000", ifc.stage_flush); end
        tick();
        for (int i = 0; i < 2; i++) begin apply(5'b00000); tick(); end
    endtask

    task automatic test_wb_flush();
        apply(5'b11100);
        vectors++; if (ifc.stage_flush !== 5'b01111) begin errors++; $display("FAIL wb_flush_vec got %b want 01111", ifc.stage_flush); end
        vectors++; if (ifc.stage_stall !== 5'b00000) begin errors++; $display("FAIL wb_flush_stall got %b want 00000", ifc.stage_stall); end
        tick();
        vectors++; if (ifc.stage_ce !== 5'b00001) begin errors++; $display("FAIL wb_flush_ce got %b want 00001", ifc.stage_ce); end
        apply(5'b10000);
        vectors++; if (ifc.stage_flush !== 5'b00000) begin errors++; $display("FAIL wb_flush_empty got %b want 00000", ifc.stage_flush); end
        tick();
        for (int i = 0; i < 4; i++) begin apply(5'b00000); tick(); end
        vectors++; if (ifc.stage_ce !== m_ce) begin errors++; $display("FAIL wb_refill_ce got %b want %b", ifc.stage_ce, m_ce); end
    endtask

    task automatic test_random();
        logic [4:0] r;
        for (int i = 0; i < 400; i++) begin
            r = '0;
            for (int b = 0; b < 5; b++)
                r[b] = ($urandom_range(0, 5) == 0);
            apply(r);
            vectors++; if (ifc.stage_stall !== m_stall) begin errors++; $display("FAIL rand_stall[%0d] req %b got %b want %b", i, r, ifc.stage_stall, m_stall); end
            vectors++; if (ifc.stage_flush !== m_flush) begin errors++; $display("FAIL rand_flush[%0d] req %b got %b want %b", i, r, ifc.stage_flush, m_flush); end
            tick();
            vectors++; if (ifc.stage_ce !== m_ce) begin errors++; $display("FAIL rand_ce[%0d] got %b want %b", i, ifc.stage_ce, m_ce); end
            vectors++; if (ifc.stall_count !== m_cnt) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", i, ifc.stall_count, m_cnt); end
        end
    endtask

    task automatic test_midreset();
        do_reset();
        for (int i = 0; i < 9; i++) begin apply(5'b00000); tick(); end
        for (int i = 0; i < 7; i++) begin apply(5'b00001); tick(); end
        for (int i = 0; i < 4; i++) begin apply(5'b00000); tick(); end
        vectors++; if (ifc.stage_ce !== 5'b11111) begin errors++; $display("FAIL midrst_pre_ce got %b want 11111", ifc.stage_ce); end
        vectors++; if (ifc.stall_count !== 32'd7) begin errors++; $display("FAIL midrst_pre_count got %0d want 7", ifc.stall_count); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (ifc.stage_ce !== 5'b00000) begin errors++; $display("FAIL midrst_ce got %b want 00000", ifc.stage_ce); end
        vectors++; if (ifc.stall_count !== 32'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", ifc.stall_count); end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            apply(5'b11111);
            vectors++; if (ifc.stage_stall !== 5'b11111 || ifc.stage_flush !== 5'b00000) begin errors++; $display("FAIL midrst_init[%0d] stall %b flush %b want 11111 00000", i, ifc.stage_stall, ifc.stage_flush); end
            tick();
            vectors++; if (ifc.stage_ce !== 5'b00000) begin errors++; $display("FAIL midrst_init_ce[%0d] got %b want 00000", i, ifc.stage_ce); end
        end
        apply(5'b00000);
        tick();
        vectors++; if (ifc.stage_ce !== 5'b00001) begin errors++; $display("FAIL midrst_run_ce got %b want 00001", ifc.stage_ce); end
        vectors++; if (ifc.stall_count !== 32'd0) begin errors++; $display("FAIL midrst_run_count got %0d want 0", ifc.stall_count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_alu_stall();
        test_mem_stall();
        test_alu_flush();
        test_wb_flush();
        test_random();
        test_midreset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
